// File: rtl/rom_loader_if.sv
// Memory write port of rom_loader: one 16-bit word per req/ack handshake.
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 22
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_wstrb;
  logic                  mem_req;
  logic                  mem_ack;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    output mem_req,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    input  mem_req,
    output mem_ack
  );
endinterface

// File: rtl/rom_loader.sv
// Packs the ROM byte stream into little-endian words, queues them in a small FIFO
// and writes them over a req/ack port; also captures the first 64 bytes as header.
module rom_loader #(
  parameter int ADDR_WIDTH = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [7:0]   rom_loading,
  input  logic [7:0]   rom_do,
  input  logic         rom_do_valid,
  rom_loader_if.master mem,
  input  logic [5:0]   hdr_raddr,
  output logic [7:0]   hdr_rdata,
  output logic [23:0]  rom_size,
  output logic         busy,
  output logic         load_done,
  output logic         overflow
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data;
    logic [1:0]            strb;
  } word_t;

  state_t                state_q;
  logic                  prev_loading_q;
  logic                  phase_q;
  logic                  overflow_q;
  logic                  busy_q;
  logic                  load_done_q;
  logic                  req_q;
  logic [23:0]           size_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            low_q;
  logic [7:0]            hdr_rdata_q;
  word_t                 out_q;
  word_t                 fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [CW-1:0]         count_q;
  logic [7:0]            hdr_mem_q [64];

  logic        loading;
  logic        start;
  logic        accept;
  logic        phase;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        full;
  logic        hdr_we;
  logic [23:0] byte_idx;
  logic [23:0] size_d;
  word_t       push_word;

  // The start cycle behaves as if size/phase were already cleared, so a byte
  // strobed on the 0->nonzero edge lands as byte 0.
  always_comb begin
    loading   = |rom_loading;
    start     = (state_q == IDLE) && loading && !prev_loading_q;
    accept    = rom_do_valid && (start || ((state_q == LOAD) && loading));
    byte_idx  = start ? '0 : size_q;
    phase     = start ? 1'b0 : phase_q;
    size_d    = (byte_idx == '1) ? byte_idx : byte_idx + 24'd1;
    hdr_we    = accept && (byte_idx < 24'd64) && resetn;
    push      = 1'b0;
    push_word = '0;
    if (accept && phase) begin
      push           = 1'b1;
      push_word.addr = waddr_q;
      push_word.data = {rom_do, low_q};
      push_word.strb = 2'b11;
    end else if ((state_q == LOAD) && !loading && phase_q) begin
      push           = 1'b1;
      push_word.addr = waddr_q;
      push_word.data = {8'h00, low_q};
      push_word.strb = 2'b01;
    end
    full    = (count_q == FULL_CNT);
    push_ok = push && !full && resetn;
    pop     = req_q && mem.mem_ack;
  end

  always_ff @(posedge clk) begin
    if (hdr_we) begin
      hdr_mem_q[byte_idx[5:0]] <= rom_do;
    end
    if (push_ok) begin
      fifo_q[wptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      prev_loading_q <= 1'b0;
      phase_q        <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      req_q          <= 1'b0;
      size_q         <= '0;
      waddr_q        <= '0;
      low_q          <= '0;
      hdr_rdata_q    <= '0;
      out_q          <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
    end else begin
      prev_loading_q <= loading;
      load_done_q    <= 1'b0;
      hdr_rdata_q    <= hdr_mem_q[hdr_raddr];

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            size_q     <= accept ? 24'd1 : 24'd0;
            waddr_q    <= '0;
            phase_q    <= accept;
            overflow_q <= 1'b0;
            if (accept) begin
              low_q <= rom_do;
            end
          end
        end
        LOAD: begin
          if (!loading) begin
            state_q <= DRAIN;
            phase_q <= 1'b0;
          end else if (accept) begin
            size_q  <= size_d;
            phase_q <= ~phase_q;
            if (!phase_q) begin
              low_q <= rom_do;
            end
          end
        end
        DRAIN: begin
          if ((count_q == '0) && !req_q) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push) begin
        waddr_q <= waddr_q + 1'b1;
        if (full) begin
          overflow_q <= 1'b1;
        end
      end

      if (start) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_ok) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
        count_q <= count_q + CW'(push_ok) - CW'(pop);
      end

      // A request only rises from the idle state, so an ack always leaves one idle cycle.
      if (pop) begin
        req_q <= 1'b0;
      end else if (!req_q && (count_q != '0)) begin
        req_q <= 1'b1;
        out_q <= fifo_q[rptr_q];
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = out_q.addr;
  assign mem.mem_wdata = out_q.data;
  assign mem.mem_wstrb = out_q.strb;
  assign hdr_rdata     = hdr_rdata_q;
  assign rom_size      = size_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_rom_loader.sv
// Randomized scoreboard bench for rom_loader: stimulus predicts memory writes from the
// byte stream, an ack responder pops and compares them as the DUT presents each write.
module tb_rom_loader;
  localparam int AW    = 22;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rom_loading = 8'h00;
  logic [7:0]  rom_do = 8'h00;
  logic        rom_do_valid = 1'b0;
  logic [5:0]  hdr_raddr = 6'd0;
  logic [7:0]  hdr_rdata;
  logic [23:0] rom_size;
  logic        busy;
  logic        load_done;
  logic        overflow;

  rom_loader_if #(.ADDR_WIDTH(AW)) mem ();

  rom_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem          (mem),
    .hdr_raddr    (hdr_raddr),
    .hdr_rdata    (hdr_rdata),
    .rom_size     (rom_size),
    .busy         (busy),
    .load_done    (load_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  int          ack_delay = -1;
  bit          ack_en = 1'b1;
  int          done_cnt = 0;
  int          sess_done0 = 0;
  int unsigned sess_bytes = 0;
  logic [7:0]  lo_byte = 8'h00;
  bit          exp_ovf = 1'b0;
  logic [7:0]  hdr_model [64];
  bit          hdr_known [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Words not yet acknowledged occupy the FIFO; a word arriving with DEPTH of them queued is lost.
  function automatic void push_exp(input int unsigned widx, input logic [15:0] data, input logic [1:0] strb);
    wr_t e;
    if (exp_q.size() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      e.addr = AW'(widx);
      e.data = data;
      e.strb = strb;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (sess_bytes < 64) begin
      hdr_model[sess_bytes] = b;
      hdr_known[sess_bytes] = 1'b1;
    end
    if (sess_bytes % 2 == 0) lo_byte = b;
    else push_exp(sess_bytes / 2, {b, lo_byte}, 2'b11);
    sess_bytes++;
  endfunction

  // Ack responder and scoreboard monitor.
  initial begin
    wr_t e;
    int  d;
    mem.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && ack_en && mem.mem_req) begin
        d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
        repeat (d) @(negedge clk);
        if (resetn && mem.mem_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem.mem_addr, mem.mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem.mem_addr), 64'(e.addr));
            chk("wr_data", 64'(mem.mem_wdata), 64'(e.data));
            chk("wr_strb", 64'(mem.mem_wstrb), 64'(e.strb));
          end
          mem.mem_ack = 1'b1;
          @(negedge clk);
          mem.mem_ack = 1'b0;
          chk("req_drop", 64'(mem.mem_req), 64'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (load_done === 1'b1) begin
      done_cnt++;
      chk("busy_at_done", 64'(busy), 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rom_do       = b;
    rom_do_valid = 1'b1;
    model_byte(b);
    @(negedge clk);
    rom_do_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_bytes(input int unsigned n, input int unsigned gmin, input int unsigned gmax, input bit idx_vals);
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(idx_vals ? 8'(sess_bytes) : 8'($urandom), $urandom_range(gmax, gmin));
    end
  endtask

  task automatic start_session(input bit byte_in_entry, input logic [7:0] b0);
    @(negedge clk);
    sess_bytes = 0;
    exp_ovf    = 1'b0;
    sess_done0 = done_cnt;
    chk("busy_before_start", 64'(busy), 64'd0);
    rom_loading = 8'($urandom_range(1, 255));
    if (byte_in_entry) begin
      rom_do       = b0;
      rom_do_valid = 1'b1;
      model_byte(b0);
    end
    @(negedge clk);
    rom_do_valid = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("ovf_cleared", 64'(overflow), 64'd0);
    chk("size_at_entry", 64'(rom_size), 64'(sess_bytes));
  endtask

  task automatic end_loading(input bit stray);
    rom_loading = 8'h00;
    if (stray) begin
      rom_do       = 8'($urandom);
      rom_do_valid = 1'b1;
    end
    if (sess_bytes % 2 == 1) push_exp(sess_bytes / 2, {8'h00, lo_byte}, 2'b01);
    @(negedge clk);
    rom_do_valid = 1'b0;
  endtask

  task automatic finish_session();
    int unsigned n = 0;
    while (done_cnt == sess_done0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 64'(done_cnt != sess_done0), 64'd1);
    @(negedge clk);
    chk("one_done", 64'(done_cnt - sess_done0), 64'd1);
    chk("rom_size", 64'(rom_size), 64'(sess_bytes));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("busy_after", 64'(busy), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_hdr();
    for (int i = 0; i < 64; i++) begin
      if (hdr_known[i]) begin
        @(negedge clk);
        hdr_raddr = 6'(i);
        @(negedge clk);
        chk("hdr_rd", 64'(hdr_rdata), 64'(hdr_model[i]));
      end
    end
  endtask

  task automatic reset_vals();
    chk("rst_req", 64'(mem.mem_req), 64'd0);
    chk("rst_addr", 64'(mem.mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem.mem_wdata), 64'd0);
    chk("rst_wstrb", 64'(mem.mem_wstrb), 64'd0);
    chk("rst_size", 64'(rom_size), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_hdr", 64'(hdr_rdata), 64'd0);
  endtask

  initial begin
    int unsigned n;
    bit          busy_seen;
    for (int i = 0; i < 64; i++) hdr_known[i] = 1'b0;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    reset_vals();
    resetn = 1'b1;
    @(negedge clk);

    // Six bytes 00..05, ack three cycles after each request.
    ack_delay = 3;
    start_session(1'b0, 8'h00);
    run_bytes(6, 3, 3, 1'b1);
    end_loading(1'b0);
    finish_session();
    ack_delay = -1;

    // Odd length: trailing byte written alone with low-byte strobe.
    start_session(1'b1, 8'hAA);
    send_byte(8'hBB, 3);
    send_byte(8'hCC, 3);
    end_loading(1'b1);
    finish_session();

    // 100 index-valued bytes, header readback.
    start_session(1'b0, 8'h00);
    run_bytes(100, 3, 4, 1'b1);
    end_loading(1'b0);
    finish_session();
    check_hdr();

    // Memory stalled while 20 bytes stream in, then released.
    start_session(1'b0, 8'h00);
    ack_en = 1'b0;
    run_bytes(20, 0, 0, 1'b0);
    @(negedge clk);
    chk("ovf_stall", 64'(overflow), 64'd1);
    ack_en = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || mem.mem_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("stall_drain", 64'(exp_q.size()), 64'd0);
    run_bytes(4, 3, 3, 1'b0);
    end_loading(1'b0);
    finish_session();

    // Reset while a write is outstanding.
    start_session(1'b0, 8'h00);
    ack_en = 1'b0;
    run_bytes(4, 0, 0, 1'b0);
    n = 0;
    while (!mem.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_before_reset", 64'(mem.mem_req), 64'd1);
    resetn      = 1'b0;
    rom_loading = 8'h00;
    @(negedge clk);
    reset_vals();
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    ack_en = 1'b1;
    start_session(1'b1, 8'($urandom));
    run_bytes(5, 3, 5, 1'b0);
    end_loading(1'b1);
    finish_session();

    // rom_loading toggles during DRAIN must not start a new session.
    start_session(1'b0, 8'h00);
    ack_en = 1'b0;
    run_bytes(6, 0, 0, 1'b0);
    end_loading(1'b0);
    rom_loading = 8'h01;
    @(negedge clk);
    rom_loading = 8'h00;
    @(negedge clk);
    rom_loading = 8'h01;
    @(negedge clk);
    ack_en = 1'b1;
    finish_session();
    busy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("no_restart", 64'(busy_seen), 64'd0);
    chk("done_count_hold", 64'(done_cnt - sess_done0), 64'd1);
    rom_loading = 8'h00;
    @(negedge clk);

    // Random sessions.
    for (int s = 0; s < 6; s++) begin
      start_session(1'($urandom_range(0, 1)), 8'($urandom));
      run_bytes($urandom_range(0, 40), 3, 5, 1'b0);
      end_loading(1'($urandom_range(0, 1)));
      finish_session();
    end
    check_hdr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
